// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, bit positions, cause codes and trap-target helper
package csr_pkg;
  localparam int A_MSTATUS   = 'h300;
  localparam int A_MISA      = 'h301;
  localparam int A_MIE       = 'h304;
  localparam int A_MTVEC     = 'h305;
  localparam int A_MSCRATCH  = 'h340;
  localparam int A_MEPC      = 'h341;
  localparam int A_MCAUSE    = 'h342;
  localparam int A_MIP       = 'h344;
  localparam int A_MHARTID   = 'hF14;
  localparam int A_MCYCLE    = 'hB00;
  localparam int A_MINSTRET  = 'hB02;
  localparam int A_MCYCLEH   = 'hB80;
  localparam int A_MINSTRETH = 'hB82;
  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MIP_MEIP  = 11;
  localparam int MIP_MTIP  = 7;
  localparam logic [3:0] CAUSE_ECALL = 4'd11;
  localparam logic [3:0] CAUSE_MTI   = 4'd7;
  localparam logic [3:0] CAUSE_MEI   = 4'd11;
  // Vectored mode (mtvec[1:0]==1) offsets interrupt traps by 4*code; everything else targets the base.
  function automatic logic [63:0] trap_target(input logic [63:0] mtvec, input logic is_irq, input logic [3:0] code);
    logic [63:0] base;
    base = {mtvec[63:2], 2'b00};
    return (is_irq && mtvec[1:0] == 2'b01) ? base + {58'd0, code, 2'b00} : base;
  endfunction
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit wrapping counter with increment enable and per-half write ports
// clk/rst: clock, sync active-high reset; i_inc: increment; i_we_lo/i_we_hi + i_wlo/i_whi: half writes
// (a write to either half suppresses the increment that cycle); o_cnt: counter value
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_we_lo,
  input  logic        i_we_hi,
  input  logic [31:0] i_wlo,
  input  logic [31:0] i_whi,
  output logic [63:0] o_cnt
);
  logic [63:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_we_lo || i_we_hi) r_cnt <= {i_we_hi ? i_whi : r_cnt[63:32], i_we_lo ? i_wlo : r_cnt[31:0]};
    else if (i_inc) r_cnt <= r_cnt + 64'd1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file with trap entry/exit, interrupt pending and optional counters
// Commit side (WBU): valid_wbu qualifies wen/waddr/wdata, is_ecall_wbu, is_mret_wbu, is_irq_wbu, pc.
// Read side (IDU): raddr -> rdata (with same-cycle write bypass); is_ecall_idu/is_mret_idu -> redirect_pc.
// ext_irq/timer_irq feed mip; irq_pending flags an enabled pending interrupt.
// Define CSR_COUNTERS_EN to add mcycle/minstret 64-bit counters.
module csr_file_m import csr_pkg::*; #(
  parameter int          XLEN        = 32,
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] MSTATUS_RST = 32'h1800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_wbu,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  is_ecall_wbu,
  input  logic                  is_mret_wbu,
  input  logic                  is_irq_wbu,
  input  logic [XLEN-1:0]       pc,
  input  logic                  ext_irq,
  input  logic                  timer_irq,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  is_ecall_idu,
  input  logic                  is_mret_idu,
  output logic [XLEN-1:0]       rdata,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  irq_pending
);
  localparam logic [XLEN-1:0] MPP  = XLEN'(2'b11) << MS_MPP_LO;
  localparam logic [XLEN-1:0] MISA = (XLEN'(XLEN == 32 ? 1 : 2) << (XLEN - 2)) | (XLEN'(1) << 8);
  localparam logic [XLEN-1:0] MIE_MASK = (XLEN'(1) << MIP_MEIP) | (XLEN'(1) << MIP_MTIP);
  logic [XLEN-1:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [XLEN-1:0] w_mip, w_cur, w_wmask, w_wval, w_cause;
  logic            w_trap, w_mret, w_wr;
  logic [3:0]      w_code;
`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle, w_minstret;
  logic [31:0] w_whi;
  logic        w_cyc_lo, w_cyc_hi, w_ret_lo, w_ret_hi;
  // With XLEN=64 one write at the low address covers the whole counter.
  assign w_whi    = XLEN == 64 ? 32'(64'(wdata) >> 32) : wdata[31:0];
  assign w_cyc_lo = w_wr && waddr == ADDR_WIDTH'(A_MCYCLE);
  assign w_ret_lo = w_wr && waddr == ADDR_WIDTH'(A_MINSTRET);
  assign w_cyc_hi = w_wr && waddr == ADDR_WIDTH'(XLEN == 64 ? A_MCYCLE : A_MCYCLEH);
  assign w_ret_hi = w_wr && waddr == ADDR_WIDTH'(XLEN == 64 ? A_MINSTRET : A_MINSTRETH);
  csr_counter64 u_mcycle (
    .clk(clk), .rst(rst), .i_inc(1'b1), .i_we_lo(w_cyc_lo), .i_we_hi(w_cyc_hi),
    .i_wlo(wdata[31:0]), .i_whi(w_whi), .o_cnt(w_mcycle)
  );
  csr_counter64 u_minstret (
    .clk(clk), .rst(rst), .i_inc(valid_wbu && !is_irq_wbu), .i_we_lo(w_ret_lo), .i_we_hi(w_ret_hi),
    .i_wlo(wdata[31:0]), .i_whi(w_whi), .o_cnt(w_minstret)
  );
`endif
  function automatic logic [XLEN-1:0] f_read(input logic [ADDR_WIDTH-1:0] a);
    case (a)
      ADDR_WIDTH'(A_MSTATUS):   return r_mstatus | MPP;
      ADDR_WIDTH'(A_MISA):      return MISA;
      ADDR_WIDTH'(A_MIE):       return r_mie;
      ADDR_WIDTH'(A_MTVEC):     return r_mtvec;
      ADDR_WIDTH'(A_MSCRATCH):  return r_mscratch;
      ADDR_WIDTH'(A_MEPC):      return r_mepc;
      ADDR_WIDTH'(A_MCAUSE):    return r_mcause;
      ADDR_WIDTH'(A_MIP):       return w_mip;
`ifdef CSR_COUNTERS_EN
      ADDR_WIDTH'(A_MCYCLE):    return XLEN'(w_mcycle);
      ADDR_WIDTH'(A_MINSTRET):  return XLEN'(w_minstret);
      ADDR_WIDTH'(A_MCYCLEH):   return XLEN == 32 ? XLEN'(w_mcycle[63:32]) : '0;
      ADDR_WIDTH'(A_MINSTRETH): return XLEN == 32 ? XLEN'(w_minstret[63:32]) : '0;
`endif
      default:                  return '0;
    endcase
  endfunction
  // Writable-bit mask per address; zero means the write leaves the register untouched.
  function automatic logic [XLEN-1:0] f_mask(input logic [ADDR_WIDTH-1:0] a);
    case (a)
      ADDR_WIDTH'(A_MSTATUS):   return ~MPP;
      ADDR_WIDTH'(A_MIE):       return MIE_MASK;
      ADDR_WIDTH'(A_MTVEC),
      ADDR_WIDTH'(A_MSCRATCH),
      ADDR_WIDTH'(A_MCAUSE):    return '1;
      ADDR_WIDTH'(A_MEPC):      return ~XLEN'(3);
`ifdef CSR_COUNTERS_EN
      ADDR_WIDTH'(A_MCYCLE),
      ADDR_WIDTH'(A_MINSTRET):  return '1;
      ADDR_WIDTH'(A_MCYCLEH),
      ADDR_WIDTH'(A_MINSTRETH): return {XLEN{XLEN == 32}};
`endif
      default:                  return '0;
    endcase
  endfunction
  assign w_mip  = (XLEN'(ext_irq) << MIP_MEIP) | (XLEN'(timer_irq) << MIP_MTIP);
  assign w_trap = valid_wbu && (is_irq_wbu || is_ecall_wbu);
  assign w_mret = valid_wbu && !is_irq_wbu && !is_ecall_wbu && is_mret_wbu;
  assign w_wr   = valid_wbu && !is_irq_wbu && !is_ecall_wbu && !is_mret_wbu && wen;
  assign w_code = (ext_irq && r_mie[MIP_MEIP]) ? CAUSE_MEI : CAUSE_MTI;
  assign w_cause = is_irq_wbu ? ((XLEN'(1) << (XLEN - 1)) | XLEN'(w_code)) : XLEN'(CAUSE_ECALL);
  always_comb begin
    w_cur   = f_read(waddr);
    w_wmask = f_mask(waddr);
    w_wval  = (wdata & w_wmask) | (w_cur & ~w_wmask);
    rdata   = (valid_wbu && wen && waddr == raddr) ? w_wval : f_read(raddr);
  end
  assign irq_pending = !rst && r_mstatus[MS_MIE] && |(r_mie & w_mip);
  assign redirect_pc = is_ecall_idu ? XLEN'(trap_target(64'(r_mtvec), 1'b0, 4'd0)) :
                       is_mret_idu  ? r_mepc : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus  <= XLEN'(MSTATUS_RST);
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else if (w_trap) begin
      r_mepc               <= pc & ~XLEN'(3);
      r_mcause             <= w_cause;
      r_mstatus[MS_MPIE]   <= r_mstatus[MS_MIE];
      r_mstatus[MS_MIE]    <= 1'b0;
    end else if (w_mret) begin
      r_mstatus[MS_MIE]    <= r_mstatus[MS_MPIE];
      r_mstatus[MS_MPIE]   <= 1'b1;
    end else if (w_wr) begin
      if (waddr == ADDR_WIDTH'(A_MSTATUS))  r_mstatus  <= w_wval;
      if (waddr == ADDR_WIDTH'(A_MIE))      r_mie      <= w_wval;
      if (waddr == ADDR_WIDTH'(A_MTVEC))    r_mtvec    <= w_wval;
      if (waddr == ADDR_WIDTH'(A_MSCRATCH)) r_mscratch <= w_wval;
      if (waddr == ADDR_WIDTH'(A_MEPC))     r_mepc     <= w_wval;
      if (waddr == ADDR_WIDTH'(A_MCAUSE))   r_mcause   <= w_wval;
    end
  end
endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: directed plus randomized check of csr_file_m against a behavioural model
module tb_csr_file_m;
  logic        clk = 1'b0;
  logic        rst, valid_wbu, wen, is_ecall_wbu, is_mret_wbu, is_irq_wbu;
  logic        ext_irq, timer_irq, is_ecall_idu, is_mret_idu, irq_pending;
  logic [11:0] waddr, raddr;
  logic [31:0] wdata, pc, rdata, redirect_pc;
  int          checks = 0;
  int          errors = 0;
  bit   [31:0] m_ms, m_mie, m_tvec, m_scr, m_epc, m_cause;
  bit   [63:0] m_cyc, m_ret;
  bit   [11:0] addrs [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                             12'hF14, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h123, 12'h7C0, 12'h000};
  always #5 clk = ~clk;
  csr_file_m #(.XLEN(32), .ADDR_WIDTH(12), .MSTATUS_RST(32'h1800)) dut (
    .clk(clk), .rst(rst), .valid_wbu(valid_wbu), .wen(wen), .waddr(waddr), .wdata(wdata),
    .is_ecall_wbu(is_ecall_wbu), .is_mret_wbu(is_mret_wbu), .is_irq_wbu(is_irq_wbu), .pc(pc),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .raddr(raddr), .is_ecall_idu(is_ecall_idu),
    .is_mret_idu(is_mret_idu), .rdata(rdata), .redirect_pc(redirect_pc), .irq_pending(irq_pending)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit [31:0] m_rd(input bit [11:0] a);
    case (a)
      12'h300: return m_ms | 32'h1800;
      12'h301: return 32'h40000100;
      12'h304: return m_mie;
      12'h305: return m_tvec;
      12'h340: return m_scr;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h344: return {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};
`ifdef CSR_COUNTERS_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction
  function automatic bit [31:0] m_after_write(input bit [11:0] a, input bit [31:0] d);
    case (a)
      12'h300: return d | 32'h1800;
      12'h304: return d & 32'h880;
      12'h305, 12'h340, 12'h342: return d;
      12'h341: return d & ~32'h3;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return d;
`endif
      default: return m_rd(a);
    endcase
  endfunction
  task automatic clr();
    {valid_wbu, wen, is_ecall_wbu, is_mret_wbu, is_irq_wbu} = '0;
    {ext_irq, timer_irq, is_ecall_idu, is_mret_idu} = '0;
    waddr = 12'h123; raddr = 12'h123; wdata = 0; pc = 0;
  endtask
  task automatic look();
    #1;
    if (!rst) begin
      chk("rdata", rdata, (valid_wbu && wen && waddr == raddr) ? m_after_write(waddr, wdata) : m_rd(raddr));
      chk("irq_pending", {31'd0, irq_pending}, {31'd0, m_ms[3] && ((m_mie & m_rd(12'h344)) != 0)});
      chk("redirect_pc", redirect_pc, is_ecall_idu ? (m_tvec & ~32'h3) : is_mret_idu ? m_epc : 32'd0);
    end
  endtask
  task automatic adv();
    bit wr_c, wr_r;
    bit [31:0] v;
    wr_c = 0; wr_r = 0;
    if (rst) begin
      m_ms = 32'h1800; m_mie = 0; m_tvec = 0; m_scr = 0; m_epc = 0; m_cause = 0; m_cyc = 0; m_ret = 0;
    end else begin
      if (valid_wbu && (is_irq_wbu || is_ecall_wbu)) begin
        m_epc   = pc & ~32'h3;
        m_cause = is_irq_wbu ? 32'h80000000 + ((ext_irq && m_mie[11]) ? 32'd11 : 32'd7) : 32'd11;
        m_ms[7] = m_ms[3];
        m_ms[3] = 1'b0;
      end else if (valid_wbu && is_mret_wbu) begin
        m_ms[3] = m_ms[7];
        m_ms[7] = 1'b1;
      end else if (valid_wbu && wen) begin
        v = m_after_write(waddr, wdata);
        case (waddr)
          12'h300: m_ms = v;
          12'h304: m_mie = v;
          12'h305: m_tvec = v;
          12'h340: m_scr = v;
          12'h341: m_epc = v;
          12'h342: m_cause = v;
`ifdef CSR_COUNTERS_EN
          12'hB00: begin m_cyc[31:0] = v; wr_c = 1; end
          12'hB80: begin m_cyc[63:32] = v; wr_c = 1; end
          12'hB02: begin m_ret[31:0] = v; wr_r = 1; end
          12'hB82: begin m_ret[63:32] = v; wr_r = 1; end
`endif
          default: ;
        endcase
      end
      if (!wr_c) m_cyc = m_cyc + 1;
      if (!wr_r && valid_wbu && !is_irq_wbu) m_ret = m_ret + 1;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    clr();
    rst = 1;
    look();
    chk("rst_unmapped", rdata, 32'd0);
    chk("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
    adv(); adv();
    rst = 0;
    raddr = 12'h300; look(); chk("mstatus_rst", rdata, 32'h1800);
    raddr = 12'h342; look(); chk("mcause_rst", rdata, 32'd0);
    adv();
    valid_wbu = 1; wen = 1; waddr = 12'h305; wdata = 32'h80000100; raddr = 12'h305;
    look(); chk("mtvec_bypass", rdata, 32'h80000100);
    adv();
    clr(); is_ecall_idu = 1;
    look(); chk("redirect_ecall", redirect_pc, 32'h80000100);
    adv();
    clr(); valid_wbu = 1; wen = 1; waddr = 12'h300; wdata = 32'h1808;
    look(); adv();
    clr(); valid_wbu = 1; is_ecall_wbu = 1; pc = 32'h80000040;
    look(); adv();
    clr();
    raddr = 12'h341; look(); chk("mepc_ecall", rdata, 32'h80000040);
    raddr = 12'h342; look(); chk("mcause_ecall", rdata, 32'd11);
    raddr = 12'h300; look(); chk("mstatus_ecall", rdata, 32'h1880);
    adv();
    clr(); valid_wbu = 1; is_mret_wbu = 1; is_mret_idu = 1;
    look(); chk("redirect_mret", redirect_pc, 32'h80000040);
    adv();
    clr(); raddr = 12'h300; look(); chk("mstatus_mret", rdata, 32'h1888);
    valid_wbu = 1; wen = 1; waddr = 12'h304; wdata = 32'hFFFFFFFF;
    look(); adv();
    clr(); ext_irq = 1; timer_irq = 1;
    look(); chk("irq_pending_on", {31'd0, irq_pending}, 32'd1);
    valid_wbu = 1; is_irq_wbu = 1; pc = 32'h80000200;
    look(); adv();
    clr(); ext_irq = 1; timer_irq = 1;
    raddr = 12'h342; look(); chk("mcause_irq", rdata, 32'h8000000B);
    raddr = 12'h300; look(); chk("mstatus_irq", rdata, 32'h1880);
    chk("irq_pending_off", {31'd0, irq_pending}, 32'd0);
    adv();
    clr(); ext_irq = 1; valid_wbu = 1; wen = 1; waddr = 12'h344; wdata = 32'hFFFFFFFF;
    look(); adv();
    clr(); ext_irq = 1; raddr = 12'h344; look(); chk("mip_ro", rdata, 32'h800);
    valid_wbu = 1; wen = 1; waddr = 12'hF14; wdata = 32'hFFFFFFFF;
    look(); adv();
    clr(); raddr = 12'hF14; look(); chk("mhartid_ro", rdata, 32'd0);
    adv();
`ifdef CSR_COUNTERS_EN
    clr(); valid_wbu = 1; wen = 1; waddr = 12'hB80; wdata = 0; look(); adv();
    waddr = 12'hB00; wdata = 32'hFFFFFFFF; look(); adv();
    clr(); look(); adv();
    raddr = 12'hB00; look(); chk("mcycle_wrap", rdata, 32'd0);
    raddr = 12'hB80; look(); chk("mcycleh_carry", rdata, 32'd1);
    adv();
    clr(); valid_wbu = 1; wen = 1; waddr = 12'hB82; wdata = 0; look(); adv();
    waddr = 12'hB02; look(); adv();
    clr();
    for (int k = 0; k < 3; k++) begin valid_wbu = 1; look(); adv(); end
    clr(); raddr = 12'hB02; look(); chk("minstret_3", rdata, 32'd3);
    adv();
`else
    clr(); valid_wbu = 1; wen = 1; waddr = 12'hB00; wdata = 32'h55;
    look(); adv();
    clr(); raddr = 12'hB00; look(); chk("mcycle_absent", rdata, 32'd0);
    adv();
`endif
    for (int i = 0; i < 400; i++) begin
      int r;
      clr();
      r = $urandom_range(0, 9);
      valid_wbu = $urandom_range(0, 3) != 0;
      is_irq_wbu = r == 0;
      is_ecall_wbu = r == 1;
      is_mret_wbu = r == 2;
      wen = r >= 3 && r <= 6;
      waddr = addrs[$urandom_range(0, 15)];
      raddr = $urandom_range(0, 3) == 0 ? waddr : addrs[$urandom_range(0, 15)];
      wdata = $urandom;
      pc = $urandom;
      ext_irq = $urandom_range(0, 1) == 1;
      timer_irq = $urandom_range(0, 1) == 1;
      is_ecall_idu = $urandom_range(0, 3) == 0;
      is_mret_idu = $urandom_range(0, 3) == 0;
      look();
      adv();
    end
    clr(); rst = 1; valid_wbu = 1; is_ecall_wbu = 1; pc = 32'h44;
    look(); adv();
    clr(); rst = 0;
    raddr = 12'h341; look(); chk("mepc_rst_trap", rdata, 32'd0);
    raddr = 12'h300; look(); chk("mstatus_rst_trap", rdata, 32'h1800);
    adv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_file_m.md
# csr_file_m

Machine-mode CSR file for the NPC core, generalised over data width, with trap entry/exit state handling, interrupt pending logic and optional 64-bit performance counters. The read port and redirect target feed IDU. Trap, mret and csrrw/csrrs/csrrc write-back are committed from WBU.

## Interface
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_WIDTH, 12, CSR address width.
- MSTATUS_RST, 32'h1800, reset value of mstatus, zero-extended to XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- valid_wbu  in  1  WBU slot valid this cycle; qualifies every commit input.
- wen  in  1  csr instruction write-back.
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  XLEN  final write value; set/clear already resolved upstream.
- is_ecall_wbu  in  1  ecall commit.
- is_mret_wbu  in  1  mret commit.
- is_irq_wbu  in  1  interrupt taken in place of the WBU instruction.
- pc  in  XLEN  PC of the WBU slot.
- ext_irq  in  1  level external interrupt; drives mip.MEIP.
- timer_irq  in  1  level timer interrupt; drives mip.MTIP.
- raddr  in  ADDR_WIDTH  IDU read address.
- is_ecall_idu  in  1  IDU wants the trap target.
- is_mret_idu  in  1  IDU wants the return target.
- rdata  out  XLEN  CSR read data.
- redirect_pc  out  XLEN  trap or return target.
- irq_pending  out  1  an enabled interrupt is pending.

## Operation
Registers:
- mstatus 0x300: MIE bit 3, MPIE bit 7, MPP [12:11] hardwired to 2'b11; other bits are writable storage.
- misa 0x301: read-only constant.
- mie 0x304: only bits 11 and 7 are writable.
- mtvec 0x305.
- mscratch 0x340.
- mepc 0x341: bits [1:0] read as 0.
- mcause 0x342.
- mip 0x344: read-only; {ext_irq at bit 11, timer_irq at bit 7}.
- mhartid 0xF14: reads 0.

Unmapped addresses read 0. Writes to them, or to read-only registers, are ignored.

Commit priority while valid_wbu=1: is_irq_wbu > is_ecall_wbu > is_mret_wbu > wen. Only one action is taken per cycle.
- **Trap (ecall or irq):**
  - mepc <= pc.
  - mcause <= 11 for ecall; {1'b1, code} for irq, with code 11 if MEIP&MEIE else 7.
  - MPIE <= MIE, then MIE <= 0.
- **mret:** MIE <= MPIE, MPIE <= 1.
- **Write (wen):** the register at waddr is written, masked by its writable bits.
- While valid_wbu=0, no CSR changes state except the counters.

Pending and read logic:
- irq_pending = MIE & |(mie & mip), combinational.
- rdata is combinational from raddr, with a write bypass: when valid_wbu & wen & waddr==raddr, rdata returns the masked wdata.

redirect_pc:
- When is_ecall_idu: mtvec base ({mtvec[XLEN-1:2],2'b00}).
- When is_mret_idu: mepc.
- Otherwise: 0.
- If mtvec[1:0]==1 (vectored), an interrupt trap targets base + 4*code. The pipeline computes that case from the same mux, exposed via a function in the package. ecall always targets base.

## Timing
- Every state update happens on the posedge following a valid commit cycle. Reads are zero-latency.
- Reset values: mstatus=MSTATUS_RST, mie=0, mtvec=0, mepc=0, mcause=0, mscratch=0, counters=0.
- Output values in reset: rdata=0 for unmapped addresses, irq_pending=0.
- rst asserted mid-trap discards the commit; reset wins over everything.
- ext_irq/timer_irq are sampled combinationally. Removing the level before is_irq_wbu leaves the chosen cause to whatever is sampled in the commit cycle. When both are pending, code 11 wins.

## Configuration
- CSR_COUNTERS_EN defined:
  - mcycle 0xB00 and minstret 0xB02 are 64-bit counters.
  - When XLEN=32, the high halves are at 0xB80/0xB82; when XLEN=64 those addresses read 0.
  - mcycle increments every cycle. minstret increments on valid_wbu & ~is_irq_wbu.
  - A write to either half replaces that half in that cycle; no increment applies that cycle.
  - Counters wrap from all-ones to 0.
- CSR_COUNTERS_EN undefined: no counter flops; those addresses read 0 and ignore writes.

## Structure
- Shared package csr_pkg holds:
  - CSR address constants.
  - mstatus/mip bit-position constants.
  - cause codes (11 ecall, 7 MTI, 11 MEI).
  - the vectored-target function.
- One sub-module, csr_counter64: a 64-bit counter with increment enable and half-word write ports, instantiated twice under CSR_COUNTERS_EN.

## Test plan
- rst, then read 0x300 -> 0x1800; read 0x342 -> 0.
- wen, waddr=0x305, wdata=0x80000100; same-cycle raddr=0x305 -> bypassed 0x80000100. Next cycle, is_ecall_idu -> redirect_pc=0x80000100.
- mstatus=0x1808, pc=0x80000040, is_ecall_wbu:
  - next cycle mepc=0x80000040, mcause=11, mstatus=0x1880.
  - then is_mret_wbu -> mstatus=0x1888.
- mie=0x880, MIE=1, ext_irq=1 and timer_irq=1 -> irq_pending=1. is_irq_wbu -> mcause=0x8000000B, MIE=0.
- Write 0x344 and 0xF14 -> reads unchanged (mip reflects inputs, mhartid=0).
- CSR_COUNTERS_EN, XLEN=32:
  - write mcycle=0xFFFFFFFF, then idle one cycle -> mcycle=0, mcycleh=1.
  - 3 valid retires -> minstret=3.
